// File: rtl/usb_hid_evq_wb.sv
// Wishbone HID port: keyboard event FIFO, clamped mouse cursor, maskable level IRQ.
// Define USB_HID_WHEEL_EN to add hid_wheel_i and the saturating wheel accumulator (reg 6).
module usb_hid_evq_wb #(
    parameter int CURS_W     = 10,
    parameter int SCREEN_W   = 1024,
    parameter int SCREEN_H   = 768,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    input  logic              wb_we_i,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    output logic              wb_ack_o,
    input  logic              hid_report_i,
    input  logic [1:0]        hid_typ_i,
    input  logic [7:0]        hid_mod_i,
    input  logic [7:0]        hid_key1_i,
    input  logic [7:0]        hid_key2_i,
    input  logic [7:0]        hid_key3_i,
    input  logic [7:0]        hid_key4_i,
    input  logic [7:0]        hid_btn_i,
    input  logic [7:0]        hid_dx_i,
    input  logic [7:0]        hid_dy_i,
`ifdef USB_HID_WHEEL_EN
    input  logic [7:0]        hid_wheel_i,
`endif
    output logic              int_o,
    output logic [CURS_W-1:0] curs_x,
    output logic [CURS_W-1:0] curs_y
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    // wide enough to hold cursor plus a full-range 8-bit signed delta
    localparam int AW = (CURS_W + 2 < 10) ? 10 : CURS_W + 2;
    localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic signed [AW-1:0] X_MAX    = AW'(SCREEN_W - 1);
    localparam logic signed [AW-1:0] Y_MAX    = AW'(SCREEN_H - 1);

    logic                         ack_q, ack_d;
    logic [31:0]                  dat_q, dat_d;
    logic                         int_q, int_d;
    logic [FIFO_DEPTH-1:0][31:0]  mem_q, mem_d;
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         ovf_q, ovf_d;
    logic [1:0]                   en_q, en_d;
    logic [7:0]                   mod_q, mod_d;
    logic [31:0]                  keys_q, keys_d;
    logic                         kb_seen_q, kb_seen_d;
    logic [1:0]                   typ_q, typ_d;
    logic [7:0]                   btn_q, btn_d, dx_q, dx_d, dy_q, dy_d;
    logic                         pend_q, pend_d;
    logic                         upd_q, upd_d;
    logic [CURS_W-1:0]            cx_q, cx_d, cy_q, cy_d;
`ifdef USB_HID_WHEEL_EN
    logic [15:0]                  whl_q, whl_d, whl_base;
    logic [16:0]                  whl_sum;
`endif

    logic                 req, rd, wr, empty, full, kb_rep, ms_rep;
    logic                 pop, flush, kb_chg, push, drop;
    logic [2:0]           idx;
    logic signed [AW-1:0] nx, ny;

    function automatic logic [CURS_W-1:0] clamp_pos(input logic signed [AW-1:0] v,
                                                    input logic signed [AW-1:0] vmax);
        if (v < 0)         return '0;
        else if (v > vmax) return CURS_W'(vmax);
        else               return CURS_W'(v);
    endfunction

    always_comb begin
        req    = wb_stb_i & wb_cyc_i & ~ack_q;
        rd     = req & ~wb_we_i;
        wr     = req & wb_we_i;
        idx    = wb_adr_i[4:2];
        empty  = (cnt_q == '0);
        full   = (cnt_q == CNT_FULL);
        kb_rep = hid_report_i & (hid_typ_i == 2'd1);
        ms_rep = hid_report_i & (hid_typ_i == 2'd2);
        pop    = rd & (idx == 3'd2) & ~empty;
        flush  = wr & (idx == 3'd5) & wb_dat_i[9];
        kb_chg = ~kb_seen_q |
                 ({hid_mod_i, hid_key1_i, hid_key2_i, hid_key3_i, hid_key4_i} != {mod_q, keys_q});
        // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
        push   = kb_rep & kb_chg & ~flush & (~full | pop);
        drop   = kb_rep & kb_chg & ~flush & full & ~pop;
        nx     = $signed(AW'(cx_q)) + $signed({{(AW-8){dx_q[7]}}, dx_q});
        ny     = $signed(AW'(cy_q)) + $signed({{(AW-8){dy_q[7]}}, dy_q});

        ack_d = req;
        dat_d = '0;
        if (rd) begin
            case (idx)
                3'd0:    dat_d = {8'(cnt_q), 5'd0, ovf_q, full, empty, 6'd0, typ_q, mod_q};
                3'd1:    dat_d = keys_q;
                3'd2:    dat_d = empty ? 32'd0 : mem_q[rd_ptr_q];
                3'd3:    dat_d = {8'd0, btn_q, dy_q, dx_q};
                3'd4:    dat_d = {16'(cy_q), 16'(cx_q)};
                3'd5:    dat_d = {30'd0, en_q};
`ifdef USB_HID_WHEEL_EN
                3'd6:    dat_d = {{16{whl_q[15]}}, whl_q};
`endif
                default: dat_d = '0;
            endcase
        end
        int_d = (en_q[0] & ~empty) | (en_q[1] & pend_q);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {hid_mod_i, hid_key1_i, hid_key2_i, hid_key3_i};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end

        en_d  = en_q;
        ovf_d = ovf_q;
        if (wr && idx == 3'd5) begin
            en_d = wb_dat_i[1:0];
            if (wb_dat_i[8])
                ovf_d = 1'b0;
        end
        if (drop)
            ovf_d = 1'b1;

        mod_d     = mod_q;
        keys_d    = keys_q;
        kb_seen_d = kb_seen_q;
        if (kb_rep) begin
            mod_d     = hid_mod_i;
            keys_d    = {hid_key1_i, hid_key2_i, hid_key3_i, hid_key4_i};
            kb_seen_d = 1'b1;
        end
        typ_d = typ_q;
        if (kb_rep || ms_rep)
            typ_d = hid_typ_i;

        btn_d  = btn_q;
        dx_d   = dx_q;
        dy_d   = dy_q;
        pend_d = pend_q;
        upd_d  = ms_rep;
        if (rd && idx == 3'd3)
            pend_d = 1'b0;
        if (ms_rep) begin
            btn_d  = hid_btn_i;
            dx_d   = hid_dx_i;
            dy_d   = hid_dy_i;
            pend_d = 1'b1;
        end

        // a CPU cursor write overrides the delta applied in the same cycle
        cx_d = cx_q;
        cy_d = cy_q;
        if (wr && idx == 3'd4) begin
            cx_d = clamp_pos($signed(AW'(wb_dat_i[CURS_W-1:0])), X_MAX);
            cy_d = clamp_pos($signed(AW'(wb_dat_i[16 +: CURS_W])), Y_MAX);
        end else if (upd_q) begin
            cx_d = clamp_pos(nx, X_MAX);
            cy_d = clamp_pos(ny, Y_MAX);
        end

`ifdef USB_HID_WHEEL_EN
        whl_base = (rd && idx == 3'd6) ? 16'd0 : whl_q;
        whl_sum  = {whl_base[15], whl_base} + {{9{hid_wheel_i[7]}}, hid_wheel_i};
        whl_d    = whl_base;
        if (ms_rep) begin
            if (whl_sum[16] != whl_sum[15])
                whl_d = whl_sum[16] ? 16'h8000 : 16'h7fff;
            else
                whl_d = whl_sum[15:0];
        end
`endif
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            int_q     <= 1'b0;
            mem_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            en_q      <= '0;
            mod_q     <= '0;
            keys_q    <= '0;
            kb_seen_q <= 1'b0;
            typ_q     <= '0;
            btn_q     <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            pend_q    <= 1'b0;
            upd_q     <= 1'b0;
            cx_q      <= '0;
            cy_q      <= '0;
`ifdef USB_HID_WHEEL_EN
            whl_q     <= '0;
`endif
        end else begin
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            int_q     <= int_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            en_q      <= en_d;
            mod_q     <= mod_d;
            keys_q    <= keys_d;
            kb_seen_q <= kb_seen_d;
            typ_q     <= typ_d;
            btn_q     <= btn_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            pend_q    <= pend_d;
            upd_q     <= upd_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
`ifdef USB_HID_WHEEL_EN
            whl_q     <= whl_d;
`endif
        end
    end

    logic unused_bits;
    assign unused_bits = ^{wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i};

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign int_o    = int_q;
    assign curs_x   = cx_q;
    assign curs_y   = cy_q;
endmodule

// File: tb/tb_usb_hid_evq_wb.sv
// Bench for usb_hid_evq_wb: queue-based reference model checked every cycle, plus literal checks.
`timescale 1ns/1ps
module tb_usb_hid_evq_wb;
    localparam int CW = 10, SW = 1024, SH = 768, DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst, we, stb, cyc, ack, rep, irq;
    logic [31:0]   adr, dat_i, dat_o;
    logic [3:0]    sel;
    logic [1:0]    typ;
    logic [7:0]    mod, k1, k2, k3, k4, btn, dx, dy, whl;
    logic [CW-1:0] cx, cy;

    always #5 clk = ~clk;

    usb_hid_evq_wb #(.CURS_W(CW), .SCREEN_W(SW), .SCREEN_H(SH), .FIFO_DEPTH(DEPTH)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
        .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_ack_o(ack),
        .hid_report_i(rep), .hid_typ_i(typ), .hid_mod_i(mod),
        .hid_key1_i(k1), .hid_key2_i(k2), .hid_key3_i(k3), .hid_key4_i(k4),
        .hid_btn_i(btn), .hid_dx_i(dx), .hid_dy_i(dy),
`ifdef USB_HID_WHEEL_EN
        .hid_wheel_i(whl),
`endif
        .int_o(irq), .curs_x(cx), .curs_y(cy));

    int n_cmp = 0, n_fail = 0;
    bit chk_en = 0;

    // reference model state
    logic [31:0] mq[$];
    bit          m_ack, m_int, m_ovf, m_pend, m_upd, m_seen;
    logic [31:0] m_dat;
    logic [1:0]  m_en, m_typ;
    logic [39:0] m_kb;
    logic [7:0]  m_btn, m_dx, m_dy;
    int          m_cx, m_cy, m_whl;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lim(input int v, input int mx);
        if (v < 0) return 0;
        if (v > mx) return mx;
        return v;
    endfunction

    function automatic int wsat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_edge();
        logic [2:0]  idx;
        bit          req, rd, wr, flush, chg;
        logic [31:0] nd;
        logic [39:0] kbv;
        int          sz;
        if (rst) begin
            mq.delete();
            m_ack = 0; m_dat = 0; m_int = 0; m_ovf = 0; m_pend = 0; m_upd = 0; m_seen = 0;
            m_en = 0; m_typ = 0; m_kb = 0; m_btn = 0; m_dx = 0; m_dy = 0;
            m_cx = 0; m_cy = 0; m_whl = 0;
            return;
        end
        idx = adr[4:2];
        req = stb && cyc && !m_ack;
        rd  = req && !we;
        wr  = req && we;
        sz  = mq.size();
        nd  = 0;
        if (rd) begin
            case (idx)
                3'd0: nd = {8'(sz), 5'd0, m_ovf, sz == DEPTH, sz == 0, 6'd0, m_typ, m_kb[39:32]};
                3'd1: nd = m_kb[31:0];
                3'd2: nd = (sz > 0) ? mq[0] : 32'd0;
                3'd3: nd = {8'd0, m_btn, m_dy, m_dx};
                3'd4: nd = {16'(m_cy), 16'(m_cx)};
                3'd5: nd = {30'd0, m_en};
`ifdef USB_HID_WHEEL_EN
                3'd6: nd = 32'(m_whl);
`endif
                default: nd = 0;
            endcase
        end
        m_int = (m_en[0] && sz != 0) || (m_en[1] && m_pend);
        m_ack = req;
        m_dat = nd;

        if (wr && idx == 3'd4) begin
            m_cx = lim(int'(dat_i[CW-1:0]), SW - 1);
            m_cy = lim(int'(dat_i[16 +: CW]), SH - 1);
        end else if (m_upd) begin
            m_cx = lim(m_cx + int'($signed(m_dx)), SW - 1);
            m_cy = lim(m_cy + int'($signed(m_dy)), SH - 1);
        end
`ifdef USB_HID_WHEEL_EN
        if (rep && typ == 2'd2)
            m_whl = wsat(((rd && idx == 3'd6) ? 0 : m_whl) + int'($signed(whl)));
        else if (rd && idx == 3'd6)
            m_whl = 0;
`endif
        m_upd = 0;
        if (rd && idx == 3'd3) m_pend = 0;
        if (rep && typ == 2'd2) begin
            m_btn = btn; m_dx = dx; m_dy = dy; m_pend = 1; m_upd = 1;
        end
        if (rep && (typ == 2'd1 || typ == 2'd2)) m_typ = typ;

        flush = wr && idx == 3'd5 && dat_i[9];
        if (wr && idx == 3'd5) begin
            m_en = dat_i[1:0];
            if (dat_i[8]) m_ovf = 0;
        end
        if (rd && idx == 3'd2 && sz > 0) void'(mq.pop_front());
        if (rep && typ == 2'd1) begin
            kbv    = {mod, k1, k2, k3, k4};
            chg    = !m_seen || kbv != m_kb;
            m_kb   = kbv;
            m_seen = 1;
            if (chg && !flush) begin
                if (mq.size() < DEPTH) mq.push_back({mod, k1, k2, k3});
                else m_ovf = 1;
            end
        end
        if (flush) mq.delete();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ack", 32'(ack), 32'(m_ack));
            if (m_ack) check("rdata", dat_o, m_dat);
            check("int_o", 32'(irq), 32'(m_int));
            check("curs_x", 32'(cx), 32'(m_cx));
            check("curs_y", 32'(cy), 32'(m_cy));
        end
    end

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic bus(input bit w, input logic [2:0] idx, input logic [31:0] d,
                       output logic [31:0] r);
        int n = 0;
        stb = 1; cyc = 1; we = w; adr = {27'd0, idx, 2'b00}; dat_i = d;
        do begin
            step();
            n++;
        end while (!ack && n < 8);
        check("bus_ack", 32'(ack), 32'd1);
        r = dat_o;
        stb = 0; cyc = 0; we = 0;
    endtask

    task automatic kb(input logic [7:0] m, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] d);
        rep = 1; typ = 2'd1; mod = m; k1 = a; k2 = b; k3 = c; k4 = d;
        step();
        rep = 0;
    endtask

    task automatic ms(input logic [7:0] x, input logic [7:0] y);
        rep = 1; typ = 2'd2; btn = 8'd0; dx = x; dy = y; whl = 8'd0;
        step();
        rep = 0;
    endtask

    initial begin
        logic [31:0] r;
        int r9;
        rst = 1; we = 0; stb = 0; cyc = 0; adr = 0; dat_i = 0; sel = 4'hf;
        rep = 0; typ = 0; mod = 0; k1 = 0; k2 = 0; k3 = 0; k4 = 0;
        btn = 0; dx = 0; dy = 0; whl = 0;
        @(negedge clk);
        step();
        chk_en = 1;
        step();
        rst = 0;
        step();

        bus(0, 3'd0, 0, r); check("status_reset", r, 32'h0001_0000);
        check("int_reset", 32'(irq), 32'd0);
        check("curs_reset", {16'(cy), 16'(cx)}, 32'd0);

        kb(8'h02, 8'h04, 0, 0, 0);
        kb(8'h02, 8'h04, 0, 0, 0);
        kb(8'h02, 8'h00, 0, 0, 0);
        bus(0, 3'd0, 0, r); check("status_kb", r, 32'h0200_0102);
        bus(0, 3'd2, 0, r); check("pop1", r, 32'h0204_0000);
        bus(0, 3'd2, 0, r); check("pop2", r, 32'h0200_0000);
        bus(0, 3'd2, 0, r); check("pop_empty", r, 32'h0000_0000);

        for (int i = 0; i < 9; i++) kb(8'h00, 8'(8'h10 + i), 0, 0, 0);
        bus(0, 3'd0, 0, r); check("status_ovf", r, 32'h0806_0100);
        bus(1, 3'd5, 32'h100, r);
        bus(0, 3'd0, 0, r); check("status_ovf_clr", r, 32'h0802_0100);
        bus(1, 3'd5, 32'h200, r);
        bus(0, 3'd0, 0, r); check("status_flush", r, 32'h0001_0100);

        ms(8'hfb, 8'hff); step();
        check("curs_neg_clamp", {16'(cy), 16'(cx)}, 32'd0);
        bus(1, 3'd4, 32'h02fd_03fc, r);
        check("curs_set", {16'(cy), 16'(cx)}, {16'd765, 16'd1020});
        ms(8'd10, 8'd10); step();
        check("curs_max_clamp", {16'(cy), 16'(cx)}, {16'd767, 16'd1023});
        ms(8'h80, 8'h00); step();
        check("curs_dx_m128", {16'(cy), 16'(cx)}, {16'd767, 16'd895});
        bus(1, 3'd4, 32'h03ff_0300, r);
        bus(0, 3'd4, 0, r); check("curs_wr_clamp", r, 32'h02ff_0300);

        bus(0, 3'd3, 0, r); check("mouse_reg", r, 32'h0000_0080);
        bus(1, 3'd5, 32'h2, r);
        ms(8'd1, 8'd1);
        check("irq_not_yet", 32'(irq), 32'd0);
        step();
        check("irq_mouse", 32'(irq), 32'd1);
        bus(0, 3'd3, 0, r); check("mouse_reg2", r, 32'h0000_0101);
        step();
        check("irq_mouse_clr", 32'(irq), 32'd0);
        kb(8'h00, 8'h55, 0, 0, 0);
        bus(1, 3'd5, 32'h1, r);
        step();
        check("irq_key", 32'(irq), 32'd1);
        bus(1, 3'd5, 32'h201, r);
        step();
        check("irq_key_flush", 32'(irq), 32'd0);

        for (int c = 0; c < 4000; c++) begin
            rst = (c == 2000);
            rep = ($urandom_range(3) == 0);
            r9  = $urandom_range(9);
            typ = (r9 < 5) ? 2'd1 : (r9 < 8) ? 2'd2 : 2'($urandom_range(3));
            mod = $urandom_range(1) ? 8'h02 : 8'h00;
            k1  = 8'($urandom_range(6, 4));
            k2  = ($urandom_range(3) == 0) ? 8'h09 : 8'h00;
            k3  = 8'h00;
            k4  = ($urandom_range(7) == 0) ? 8'h0a : 8'h00;
            btn = 8'($urandom); dx = 8'($urandom); dy = 8'($urandom); whl = 8'($urandom);
            if (!stb && $urandom_range(2) == 0) begin
                stb = 1; cyc = 1; we = 1'($urandom_range(1));
                adr = $urandom;
                adr[4:2] = 3'($urandom_range(7));
                if (adr[4:2] == 3'd5)
                    dat_i = {22'd0, $urandom_range(3) == 0, $urandom_range(3) == 0, 6'd0,
                             2'($urandom_range(3))};
                else
                    dat_i = $urandom;
            end
            step();
            if (ack) begin stb = 0; cyc = 0; we = 0; end
        end
        rst = 0; stb = 0; cyc = 0; rep = 0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
